mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one memory port between instruction fetch (I) and load/store (D) requesters of the core.
//  Sits between the fetch/LSU front ends and a variable-latency memory; one transaction outstanding.
//  Owns arbitration, latching of request fields, response routing and a memory-ack timeout.
// PARAMETERS
//  AW      32  address width
//  DW      32  data width; byte enables are DW/8 wide
//  TMO_CYC 64  BUSY cycles without m_ack before an error response; 0 disables the timeout
// PORTS
//  clk       in   1     clock, all state on rising edge
//  rst       in   1     asynchronous, active-high reset
//  if_req    in   1     fetch request; held with if_addr stable until if_gnt
//  if_addr   in   AW    fetch address
//  if_gnt    out  1     fetch request accepted (combinational, 1-cycle pulse)
//  if_rvalid out  1     fetch response valid (registered, 1-cycle pulse)
//  if_rdata  out  DW    fetch read data
//  if_err    out  1     fetch response is a timeout error; qualified by if_rvalid
//  d_req     in   1     data request; fields held stable until d_gnt
//  d_we      in   1     1 = store, 0 = load
//  d_addr    in   AW    data address
//  d_wdata   in   DW    store data
//  d_be      in   DW/8  store byte enables
//  d_gnt     out  1     data request accepted (combinational, 1-cycle pulse)
//  d_rvalid  out  1     data response / store completion (registered, 1-cycle pulse)
//  d_rdata   out  DW    load data
//  d_err     out  1     data response is a timeout error; qualified by d_rvalid
//  m_req     out  1     memory request, held high until m_ack or timeout
//  m_we      out  1     memory write strobe
//  m_addr    out  AW    memory address (registered)
//  m_wdata   out  DW    memory write data (registered)
//  m_be      out  DW/8  memory byte enables (registered)
//  m_ack     in   1     memory completion; m_rdata valid in the same cycle
//  m_rdata   in   DW    memory read data
// BEHAVIOUR
//  Reset: state IDLE, owner=D, last_gnt=D, timeout count 0; every output 0.
//  FSM IDLE: winner of {if_req,d_req} gets gnt that cycle; on the edge, latch addr/we/wdata/be
//    into m_*, record owner, m_req<=1, count<=0, go BUSY. No req: stay IDLE, m_req=0.
//  FSM BUSY: no gnt issued; m_* stable. m_ack=1: owner's rvalid<=1, rdata<=m_rdata (0 for stores),
//    err<=0, m_req<=0, go IDLE. Else count++; TMO_CYC!=0 and count==TMO_CYC-1: owner's rvalid<=1,
//    err<=1, rdata<=0, m_req<=0, go IDLE. m_ack on the terminal-count cycle wins (normal response).
//  Latency: gnt -> m_req 1 cycle; m_ack -> rvalid 1 cycle; min gnt -> rvalid 2 cycles.
//  Back-to-back: rvalid cycle is an IDLE cycle, so a new gnt may coincide with rvalid.
//  Non-owner rvalid/err stay 0; rdata outputs hold last value when rvalid=0.
//  m_ack in IDLE is ignored. req dropped before gnt is legal; nothing is latched.
//  Count is $clog2(TMO_CYC+1) bits, saturating; never wraps.
//  rst mid-BUSY: transaction dropped, no rvalid, m_req falls asynchronously.
// CONFIGURATION
//  MEMARB_RR_EN undefined: fixed priority, D beats I on contention.
//  MEMARB_RR_EN defined: round-robin; on contention the port not in last_gnt wins; last_gnt
//    updates on every gnt. After reset the first contention therefore goes to I.
// STRUCTURE
//  cpu.vh: MA_IDLE/MA_BUSY state encodings, MA_OWN_I/MA_OWN_D owner codes, default TMO_CYC.
//  Sub-module memarb_tmo: clear/enable saturating counter with terminal-count output.
// TESTING
//  1 Single load: d_req, d_addr=0x100, m_ack 3 cycles after m_req, m_rdata=0xDEADBEEF
//    -> d_gnt pulse, d_rvalid 1 cycle after m_ack, d_rdata=0xDEADBEEF, d_err=0, if_rvalid=0.
//  2 Contention: if_req & d_req same cycle, fixed priority -> d_gnt first, if_gnt on the d_rvalid
//    cycle; with MEMARB_RR_EN after reset -> if_gnt first, then d_gnt.
//  3 Timeout: TMO_CYC=4, fetch 0x40, m_ack never -> if_rvalid & if_err 4 cycles after m_req
//    rises, if_rdata=0, m_req low, next request accepted.
//  4 Store: d_we=1, d_addr=0x200, d_wdata=0x12345678, d_be=4'b0011 -> m_* match for whole BUSY,
//    d_rvalid with d_rdata=0 after m_ack.
//  5 Reset mid-BUSY: assert rst 2 cycles into BUSY -> m_req/all outputs 0 immediately, no rvalid.
//  6 Ack at terminal count: TMO_CYC=4, m_ack on the 4th BUSY cycle -> rvalid with err=0, data valid.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared types and constants for the I/D memory arbiter:
//               FSM state encodings, transaction owner codes and the
//               default memory-ack timeout length.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [0:0] {
        MA_IDLE = 1'b0,
        MA_BUSY = 1'b1
    } state_t;

    // Which requester owns the outstanding transaction
    typedef enum logic [0:0] {
        MA_OWN_I = 1'b0,
        MA_OWN_D = 1'b1
    } owner_t;

    // BUSY cycles without m_ack before an error response (0 = no timeout)
    localparam int TMO_CYC_DEFAULT = 64;

endpackage : mem_arbiter_pkg

`default_nettype wire

// File: rtl/mem_arbiter_tmo.sv
// ============================================================================
// Module      : mem_arbiter_tmo
// Description : Clear/enable saturating counter with terminal-count output,
//               used as the memory-ack timeout of mem_arbiter.
// Ports       : clk, rst (async, active-high)
//               clr  - synchronous clear to zero (wins over en)
//               en   - count enable
//               tc   - count has reached TMO_CYC-1 (always 0 if TMO_CYC==0)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter_tmo
    import mem_arbiter_pkg::*;
#(
    parameter int TMO_CYC = TMO_CYC_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    // Width $clog2(TMO_CYC+1), with a 1-bit floor for the disabled case
    localparam int CW = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;

    generate
        if (TMO_CYC == 0) begin : g_tmo_off
            assign tc = 1'b0;
        end else begin : g_tmo_on
            logic [CW-1:0] count;

            // Saturates at TMO_CYC so a stalled enable can never wrap
            // the count back through the terminal value.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    count <= '0;
                end else if (clr) begin
                    count <= '0;
                end else if (en && (count != CW'(TMO_CYC))) begin
                    count <= count + 1'b1;
                end
            end

            assign tc = (count == CW'(TMO_CYC - 1));
        end
    endgenerate

endmodule : mem_arbiter_tmo

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one variable-latency memory port between instruction
//               fetch (I) and load/store (D) requesters. One transaction
//               outstanding; request fields are latched on grant, the
//               response is routed back to the owner, and a memory-ack
//               timeout produces an error response.
// Ports       : clk, rst (async, active-high)
//               if_req/if_addr -> if_gnt (comb), if_rvalid/if_rdata/if_err
//               d_req/d_we/d_addr/d_wdata/d_be -> d_gnt (comb),
//                   d_rvalid/d_rdata/d_err
//               m_req/m_we/m_addr/m_wdata/m_be (registered), m_ack/m_rdata
// Config      : MEMARB_RR_EN defined   -> round-robin on contention
//               MEMARB_RR_EN undefined -> fixed priority, D beats I
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TMO_CYC = TMO_CYC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    // instruction fetch port
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    output logic            if_err,
    // load/store port
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            d_err,
    // memory port
    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_be,
    input  logic            m_ack,
    input  logic [DW-1:0]   m_rdata
);

    state_t state;
    owner_t owner;
    logic   prefer_d;
    logic   pick_d;
    logic   tmo_tc;

`ifdef MEMARB_RR_EN
    owner_t last_gnt;
    // On contention the port that did not win last time goes first
    assign prefer_d = (last_gnt == MA_OWN_I);
`else
    assign prefer_d = 1'b1;
`endif

    assign pick_d = d_req & (~if_req | prefer_d);
    assign d_gnt  = (state == MA_IDLE) & pick_d;
    assign if_gnt = (state == MA_IDLE) & if_req & ~pick_d;

    mem_arbiter_tmo #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo (
        .clk (clk),
        .rst (rst),
        .clr (state == MA_IDLE),
        .en  ((state == MA_BUSY) & ~m_ack),
        .tc  (tmo_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= MA_IDLE;
            owner     <= MA_OWN_D;
`ifdef MEMARB_RR_EN
            last_gnt  <= MA_OWN_D;
`endif
            m_req     <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            m_be      <= '0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            if_err    <= 1'b0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
            d_err     <= 1'b0;
        end else begin
            // Responses are single-cycle pulses; rdata holds its last value
            if_rvalid <= 1'b0;
            if_err    <= 1'b0;
            d_rvalid  <= 1'b0;
            d_err     <= 1'b0;

            case (state)
                MA_IDLE: begin
                    if (d_gnt) begin
                        m_we    <= d_we;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        m_be    <= d_be;
                        owner   <= MA_OWN_D;
`ifdef MEMARB_RR_EN
                        last_gnt <= MA_OWN_D;
`endif
                        m_req   <= 1'b1;
                        state   <= MA_BUSY;
                    end else if (if_gnt) begin
                        m_we    <= 1'b0;
                        m_addr  <= if_addr;
                        m_wdata <= '0;
                        m_be    <= '0;
                        owner   <= MA_OWN_I;
`ifdef MEMARB_RR_EN
                        last_gnt <= MA_OWN_I;
`endif
                        m_req   <= 1'b1;
                        state   <= MA_BUSY;
                    end else begin
                        m_req   <= 1'b0;
                    end
                end

                MA_BUSY: begin
                    // An ack on the terminal-count cycle is a normal response
                    if (m_ack || tmo_tc) begin
                        if (owner == MA_OWN_D) begin
                            d_rvalid <= 1'b1;
                            d_err    <= ~m_ack;
                            d_rdata  <= (m_ack && !m_we) ? m_rdata : '0;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_err    <= ~m_ack;
                            if_rdata  <= m_ack ? m_rdata : '0;
                        end
                        m_req <= 1'b0;
                        state <= MA_IDLE;
                    end
                end

                default: begin
                    m_req <= 1'b0;
                    state <= MA_IDLE;
                end
            endcase
        end
    end

endmodule : mem_arbiter

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter (TMO_CYC = 4).
//               Directed transaction table plus hand-written contention,
//               reset-mid-BUSY and idle-ack sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    logic        m_ack = 1'b0;
    logic [31:0] m_rdata = 32'h0BAD_0BAD;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32), .TMO_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_be(d_be), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_be(m_be), .m_ack(m_ack), .m_rdata(m_rdata)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ack_cyc: BUSY cycle (1 = first) in which m_ack is driven, 0 = never
    // exp_cyc: BUSY cycle after whose closing edge rvalid is expected
    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          ack_cyc;
        logic [31:0] mem_data;
        int          exp_cyc;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input int idx);
        bit   got = 0;
        logic rv, er;
        logic [31:0] rd;
        d_req = v.is_d; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
        if_req = !v.is_d; if_addr = v.addr;
        #1;
        chk($sformatf("v%0d own_gnt", idx), v.is_d ? d_gnt : if_gnt, 1);
        chk($sformatf("v%0d other_gnt", idx), v.is_d ? if_gnt : d_gnt, 0);
        tick();
        // scramble request fields: m_* must keep the latched copy
        d_req = 0; if_req = 0;
        d_addr = 32'hFFFF_FFFF; if_addr = 32'hFFFF_FFFF; d_wdata = ~v.wdata; d_be = ~v.be; d_we = !v.we;
        for (int k = 1; k <= 8 && !got; k++) begin
            chk($sformatf("v%0d m_req c%0d", idx, k), m_req, 1);
            chk($sformatf("v%0d m_addr c%0d", idx, k), m_addr, v.addr);
            chk($sformatf("v%0d m_we c%0d", idx, k), m_we, v.we);
            if (v.is_d && v.we) begin
                chk($sformatf("v%0d m_wdata c%0d", idx, k), m_wdata, v.wdata);
                chk($sformatf("v%0d m_be c%0d", idx, k), m_be, v.be);
            end
            if (k == v.ack_cyc) begin
                m_ack = 1; m_rdata = v.mem_data;
            end
            tick();
            m_ack = 0; m_rdata = 32'h0BAD_0BAD;
            rv = v.is_d ? d_rvalid : if_rvalid;
            if (rv) begin
                got = 1;
                rd = v.is_d ? d_rdata : if_rdata;
                er = v.is_d ? d_err : if_err;
                chk($sformatf("v%0d rvalid_cycle", idx), k, v.exp_cyc);
                chk($sformatf("v%0d rdata", idx), rd, v.exp_rdata);
                chk($sformatf("v%0d err", idx), er, v.exp_err);
                chk($sformatf("v%0d other_rvalid", idx), v.is_d ? if_rvalid : d_rvalid, 0);
                chk($sformatf("v%0d m_req_low", idx), m_req, 0);
            end
        end
        if (!got) chk($sformatf("v%0d rvalid_seen", idx), 0, 1);
        tick();
        chk($sformatf("v%0d rvalid_pulse", idx), v.is_d ? d_rvalid : if_rvalid, 0);
        chk($sformatf("v%0d rdata_hold", idx), v.is_d ? d_rdata : if_rdata, v.exp_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_d_first;
        vecs[0] = '{1, 0, 32'h100, 32'h0,        4'h0, 3, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 0};
        vecs[1] = '{0, 0, 32'h40,  32'h0,        4'h0, 0, 32'h0,         4, 32'h0,         1};
        vecs[2] = '{1, 1, 32'h200, 32'h1234_5678, 4'b0011, 2, 32'hAAAA_5555, 2, 32'h0,     0};
        vecs[3] = '{0, 0, 32'h44,  32'h0,        4'h0, 4, 32'h1357_9BDF, 4, 32'h1357_9BDF, 0};
        vecs[4] = '{1, 0, 32'h104, 32'h0,        4'h0, 0, 32'h0,         4, 32'h0,         1};
        vecs[5] = '{0, 0, 32'h48,  32'h0,        4'h0, 1, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 0};

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst m_req", m_req, 0);
        chk("rst m_addr", m_addr, 0);
        chk("rst m_wdata", m_wdata, 0);
        chk("rst m_be_we", {m_be, m_we}, 0);
        chk("rst rvalids", {if_rvalid, d_rvalid, if_err, d_err}, 0);
        chk("rst rdatas", {if_rdata, d_rdata}, 0);
        chk("rst gnts", {if_gnt, d_gnt}, 0);
        rst = 0;
        tick();

        // ---- contention right after reset ----
`ifdef MEMARB_RR_EN
        exp_d_first = 0;
`else
        exp_d_first = 1;
`endif
        if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h300;
        #1;
        chk("cont first d_gnt", d_gnt, exp_d_first);
        chk("cont first if_gnt", if_gnt, !exp_d_first);
        tick();
        if (exp_d_first) d_req = 0; else if_req = 0;
        chk("cont busy gnts", {if_gnt, d_gnt}, 0);
        chk("cont first m_addr", m_addr, exp_d_first ? 32'h300 : 32'h80);
        m_ack = 1; m_rdata = 32'h1111_1111;
        tick();
        m_ack = 0;
        chk("cont first rvalid", exp_d_first ? d_rvalid : if_rvalid, 1);
        chk("cont second gnt", exp_d_first ? if_gnt : d_gnt, 1);
        tick();
        if_req = 0; d_req = 0;
        chk("cont second m_addr", m_addr, exp_d_first ? 32'h80 : 32'h300);
        chk("cont second m_req", m_req, 1);
        m_ack = 1; m_rdata = 32'h2222_2222;
        tick();
        m_ack = 0;
        chk("cont second rvalid", exp_d_first ? if_rvalid : d_rvalid, 1);
        chk("cont second rdata", exp_d_first ? if_rdata : d_rdata, 32'h2222_2222);
        chk("cont first rdata held", exp_d_first ? d_rdata : if_rdata, 32'h1111_1111);
        tick();

        // ---- directed transaction table ----
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
        end

        // ---- reset two cycles into BUSY ----
        d_req = 1; d_we = 0; d_addr = 32'h300;
        tick();
        d_req = 0;
        tick();
        chk("rstbusy m_req before", m_req, 1);
        rst = 1;
        #1;
        chk("rstbusy m_req async", m_req, 0);
        chk("rstbusy m_addr", m_addr, 0);
        chk("rstbusy outs", {d_rvalid, if_rvalid, d_err, if_err, m_we}, 0);
        tick();
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) m_ack = 1;   // ack while IDLE must be ignored
            tick();
            m_ack = 0;
            chk($sformatf("rstbusy no_rvalid %0d", k), {d_rvalid, if_rvalid}, 0);
            chk($sformatf("rstbusy idle m_req %0d", k), m_req, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_mem_arbiter

`default_nettype wire
